// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the load/store bridge,
// one-shot (latched IRQ) or auto-reload (periodic 1-cycle IRQ pulse) operation.
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_flag, irq_flag_n;

  logic        hit, wr_ctrl, wr_preset;
  logic        en, im, auto_reload;
  logic [1:0]  unused_addr;

  // Saturating decrement: COUNT never wraps below zero.
  function automatic logic [31:0] dec_sat(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  assign unused_addr = Addr[1:0];
  assign hit         = (Addr[31:4] == BASE[31:4]);
  assign wr_ctrl     = WE && hit && (Addr[3:2] == 2'd0);
  assign wr_preset   = WE && hit && (Addr[3:2] == 2'd1);

  assign en          = ctrl[0];
  assign im          = ctrl[3];
  assign auto_reload = (ctrl[2:1] == 2'b01);

  assign IRQ = im & irq_flag;

  always_comb begin
    Dout = 32'd0;
    if (hit) begin
      case (Addr[3:2])
        2'd0:    Dout = {28'd0, ctrl};
        2'd1:    Dout = preset;
        2'd2:    Dout = count;
        default: Dout = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    ctrl_n     = ctrl;
    preset_n   = preset;
    count_n    = count;
    irq_flag_n = irq_flag;

    case (state)
      S_IDLE: if (en) state_n = S_LOAD;
      S_LOAD: begin
        count_n    = preset;
        irq_flag_n = 1'b0;
        state_n    = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_n = S_IDLE;
        end else if (count > 32'd1) begin
          count_n = dec_sat(count);
        end else begin
          count_n    = 32'd0;
          irq_flag_n = 1'b1;
          state_n    = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) irq_flag_n = 1'b0;
        else             ctrl_n[0]  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // CPU writes are applied last so they override the FSM's own updates.
    if (wr_ctrl) begin
      ctrl_n     = Din[3:0];
      irq_flag_n = 1'b0;
    end
    if (wr_preset) begin
      preset_n   = Din;
      irq_flag_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= irq_flag_n;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expectations are queued as stimulus is applied and
// popped when the corresponding register read or IRQ sample is taken.
module tb_timer_dev;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  timer_dev #(.BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0h required=queued_expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push(tag, exp);
    Addr = a;
    WE   = 1'b0;
    #1;
    check(Dout);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push(tag, {31'd0, exp});
    check({31'd0, IRQ});
  endtask

  initial begin
    // Reset with a write strobe active: nothing may stick.
    reset = 1'b1;
    WE    = 1'b1;
    Addr  = A_CTRL;
    Din   = $urandom;
    repeat (2) @(posedge clk);
    Addr  = A_PRE;
    Din   = $urandom;
    @(posedge clk);
    #1;
    WE = 1'b0;
    chk_rd("rst_ctrl", A_CTRL, 32'd0);
    chk_rd("rst_preset", A_PRE, 32'd0);
    chk_rd("rst_count", A_CNT, 32'd0);
    chk_irq("rst_irq", 1'b0);
    reset = 1'b0;

    // Register map basics.
    wr(A_PRE, 32'hDEAD_BEEF);
    chk_rd("preset_rb", A_PRE, 32'hDEAD_BEEF);
    wr(A_CNT, 32'd5);
    chk_rd("count_ro", A_CNT, 32'd0);
    wr(A_RSV, 32'h1234_5678);
    chk_rd("rsv_zero", A_RSV, 32'd0);
    chk_rd("nonhit_zero", BASE + 32'h10, 32'd0);
    wr(A_CTRL, 32'hFFFF_FFF0);
    chk_rd("ctrl_4bit", A_CTRL, 32'd0);

    // One-shot, PRESET=3.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h9);
    push("os_cnt_e1", 32'd0);
    push("os_cnt_e2", 32'd3);
    push("os_cnt_e3", 32'd2);
    push("os_cnt_e4", 32'd1);
    push("os_cnt_e5", 32'd0);
    Addr = A_CNT;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check(Dout);
    end
    chk_irq("os_irq_e5", 1'b1);
    tick();
    chk_rd("os_ctrl_e6", A_CTRL, 32'h8);
    chk_irq("os_irq_e6", 1'b1);
    repeat (3) tick();
    chk_irq("os_irq_held", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("os_irq_ack", 1'b0);
    tick();
    chk_irq("os_irq_ack2", 1'b0);

    // Auto-reload, PRESET=2: 5-cycle period, 1-cycle IRQ.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'hB);
    Addr = A_CTRL;
    for (int k = 1; k <= 20; k++) begin
      push("ar_ctrl", 32'hB);
      push($sformatf("ar_irq_%0d", k), {31'd0, (k >= 4) && (((k - 4) % 5) == 0)});
      tick();
      check(Dout);
      check({31'd0, IRQ});
    end
    wr(A_CTRL, 32'h0);

    // Pause at COUNT=6 then restart from PRESET.
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (5) tick();
    chk_rd("pause_cnt7", A_CNT, 32'd7);
    wr(A_CTRL, 32'h8);
    chk_rd("pause_cnt6", A_CNT, 32'd6);
    repeat (4) tick();
    chk_rd("pause_hold", A_CNT, 32'd6);
    chk_irq("pause_noirq", 1'b0);
    wr(A_CTRL, 32'h9);
    chk_rd("resume_f0", A_CNT, 32'd6);
    tick();
    chk_rd("resume_f1", A_CNT, 32'd6);
    tick();
    chk_rd("resume_f2", A_CNT, 32'd10);
    tick();
    chk_rd("resume_f3", A_CNT, 32'd9);
    wr(A_CTRL, 32'h0);

    // Masked one-shot, PRESET=2.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    repeat (4) tick();
    chk_irq("mask_irq_int", 1'b0);
    chk_rd("mask_cnt0", A_CNT, 32'd0);
    tick();
    chk_rd("mask_en_clr", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h8);
    chk_irq("mask_im_set", 1'b0);
    tick();
    chk_irq("mask_im_set2", 1'b0);

    // CTRL write on the INT edge keeps EN and clears irq_flag.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h9);
    repeat (4) tick();
    chk_irq("col_irq_int", 1'b1);
    wr(A_CTRL, 32'h9);
    chk_rd("col_ctrl", A_CTRL, 32'h9);
    chk_irq("col_irq_clr", 1'b0);
    tick();
    chk_rd("col_load", A_CNT, 32'd0);
    tick();
    chk_rd("col_reload", A_CNT, 32'd2);
    wr(A_CTRL, 32'h0);

    // CTRL write on the edge where CNT would set irq_flag.
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h9);
    repeat (2) tick();
    chk_rd("col2_cnt1", A_CNT, 32'd1);
    wr(A_CTRL, 32'h9);
    chk_irq("col2_noirq", 1'b0);
    wr(A_CTRL, 32'h0);

    // PRESET=0 behaves like PRESET=1.
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    repeat (2) tick();
    chk_rd("p0_cnt", A_CNT, 32'd0);
    chk_irq("p0_irq_e2", 1'b0);
    tick();
    chk_irq("p0_irq_e3", 1'b1);
    wr(A_CTRL, 32'h0);

    // MODE=10 is one-shot.
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'hD);
    repeat (4) tick();
    chk_rd("m10_en_clr", A_CTRL, 32'hC);
    chk_irq("m10_irq", 1'b1);

    // Reset mid-count with WE active.
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'hF);
    repeat (3) tick();
    chk_rd("mid_cnt4", A_CNT, 32'd4);
    reset = 1'b1;
    Addr  = A_CTRL;
    Din   = 32'hF;
    WE    = 1'b1;
    tick();
    WE = 1'b0;
    chk_rd("mid_rst_ctrl", A_CTRL, 32'd0);
    chk_rd("mid_rst_pre", A_PRE, 32'd0);
    chk_rd("mid_rst_cnt", A_CNT, 32'd0);
    chk_irq("mid_rst_irq", 1'b0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
